// File: rtl/obuffer_drain.sv
// Write-back buffer: collects result bytes into a small FIFO, then drains them
// in order to SDRAM over a req/ack port with an auto-incrementing address.
module obuffer_drain #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              push,
  input  logic [7:0]        push_data,
  input  logic              flush,
  output logic              full,
  output logic              busy,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack,
  output logic              done
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH-1:0][7:0]   mem_q, mem_d;
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    push_ok;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    push_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_addr) addr_d = start_addr;
        push_ok = push && (count_q != CNT_FULL);
        if (push_ok) begin
          mem_d[tail_q] = push_data;
          tail_d        = tail_q + 1'b1;
          count_d       = count_q + 1'b1;
        end
        // a same-cycle push counts toward the flush decision
        if (count_d == CNT_FULL) state_d = WRITE;
        else if (flush)          state_d = (count_d != '0) ? WRITE : DONE;
      end
      WRITE: begin
        if (wr_ack) begin
          head_d  = head_q + 1'b1;
          count_d = count_q - 1'b1;
          addr_d  = addr_q + 1'b1;
          if (count_q == CW'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign full    = busy || (count_q == CNT_FULL);
  assign wr_req  = (state_q == WRITE);
  assign done    = (state_q == DONE);
  assign wr_addr = addr_q;
  assign wr_data = mem_q[head_q];
endmodule
